// File: rtl/mem_pkg.sv
// Shared definitions for the vector-store datapath (serializer, store sequencer, loader).
// Holds the default geometry, the store FSM encoding and the word/address types.
package mem_pkg;

  localparam int DATA_W = 16;
  localparam int LANES  = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STORE = 2'd1,
    ST_DONE  = 2'd2
  } store_state_t;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mem_addr_gen.sv
// Lane address generator: load computes the top-lane address, each step walks one stride down.
// Kept free of FSM knowledge so a vector-load gatherer can reuse it.
module mem_addr_gen #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int LANES  = mem_pkg::LANES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] cur_addr
);

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;

  // Lanes are delivered highest first, so start at base + (LANES-1)*stride and walk down.
  // Both the precompute and the decrement wrap modulo 2^ADDR_W.
  always_comb begin
    cur_addr_d = cur_addr_q;
    stride_d   = stride_q;
    if (load) begin
      cur_addr_d = base + ADDR_W'(LANES - 1) * stride;
      stride_d   = stride;
    end else if (step) begin
      cur_addr_d = cur_addr_q - stride_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q <= '0;
      stride_q   <= '0;
    end else begin
      cur_addr_q <= cur_addr_d;
      stride_q   <= stride_d;
    end
  end

  assign cur_addr = cur_addr_q;

endmodule

// File: rtl/mem_store_sequencer.sv
// Vector-store sequencer: takes the serialized lane stream and drives the data-RAM write port.
// Lane i of a vector lands at base_addr + i*stride; done pulses after the last write.
module mem_store_sequencer #(
  parameter int DATA_W = mem_pkg::DATA_W,
  parameter int LANES  = mem_pkg::LANES,
  parameter int ADDR_W = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_in,
  output logic              word_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              stray_err,
  output logic [1:0]        dbg_state
);
  import mem_pkg::*;

  // Handshake: a beat is word_valid & word_ready on a rising clk edge. word_ready is a
  // pure function of state (high only in STORE) and never depends on word_valid.

  localparam int CNT_W = $clog2(LANES) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LANES - 1);

  store_state_t      state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              stray_err_q, stray_err_d;

  logic              ag_load;
  logic              ag_step;
  logic [ADDR_W-1:0] cur_addr;
  logic              beat;

  mem_addr_gen #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (ag_load),
    .step     (ag_step),
    .base     (base_addr),
    .stride   (stride),
    .cur_addr (cur_addr)
  );

  assign beat = (state_q == ST_STORE) && word_valid;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    ag_load     = 1'b0;
    ag_step     = 1'b0;
    // Any word offered outside STORE is dropped and flagged, including alongside start.
    stray_err_d = word_valid && (state_q != ST_STORE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ag_load    = 1'b1;
          beat_cnt_d = '0;
          state_d    = ST_STORE;
        end
      end
      ST_STORE: begin
        if (beat) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cur_addr;
          mem_wdata_d = word_in;
          ag_step     = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = ST_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      stray_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      stray_err_q <= stray_err_d;
    end
  end

  assign word_ready = (state_q == ST_STORE);
  assign busy       = (state_q != ST_IDLE);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign done       = done_q;
  assign stray_err  = stray_err_q;
  assign dbg_state  = state_q;

endmodule
